instruction_fetch_queue: RTL

//  Front-end stage feeding instruction decode. Holds the PC, fetches 32-bit words from

---
 rtl/ifetch_pkg.sv | 13 +
 rtl/instruction_fetch_queue_if.sv | 23 ++
 rtl/instruction_fetch_queue_fetch_fifo.sv | 38 +++
 rtl/instruction_fetch_queue.sv | 63 ++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, reset PC, fetch FSM states and FIFO entry type
package ifetch_pkg;
  localparam int XLEN = 32;
  localparam int QDEPTH = 4;
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h00000013;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_queue_if.sv
// instruction_fetch_queue_if: memory, decode and redirect signals of the fetch queue
interface instruction_fetch_queue_if;
  import ifetch_pkg::*;
  logic mem_req;
  logic [XLEN-1:0] mem_addr;
  logic mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic available;
  logic decode_pulse;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [CW-1:0] fq_count;
  modport master (
    output mem_req, mem_addr, decode_pulse, instr, instr_pc, fq_count,
    input mem_ack, mem_rdata, available, redirect, redirect_pc
  );
  modport slave (
    input mem_req, mem_addr, decode_pulse, instr, instr_pc, fq_count,
    output mem_ack, mem_rdata, available, redirect, redirect_pc
  );
endinterface

// File: rtl/instruction_fetch_queue_fetch_fifo.sv
// fetch_fifo: QDEPTH-entry {pc, instr} queue; occupancy count decides empty/full
module fetch_fifo
  import ifetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);
  localparam int PW = $clog2(QDEPTH);
  fetch_entry_t mem [QDEPTH];
  logic [PW-1:0] wp, rp;
  assign head = mem[rp];
  // pointers and occupancy; flush empties the queue in one cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // storage needs no reset: entries are only read once counted as valid
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wp] <= din;
  end
endmodule

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: PC register, single-outstanding fetch FSM and decode issue register
module instruction_fetch_queue
  import ifetch_pkg::*;
(
  input logic clock,
  input logic reset_n,
  instruction_fetch_queue_if.master bus
);
  fetch_state_t state, state_n;
  logic [XLEN-1:0] pc, req_addr;
  logic push, pop, issue;
  logic [CW-1:0] count;
  fetch_entry_t head;
  assign issue = state == IDLE && !bus.redirect && count < CW'(QDEPTH);
  assign push = state == WAIT && bus.mem_ack && !bus.redirect;
  assign pop = count != '0 && bus.available && !bus.redirect;
  assign bus.mem_req = state != IDLE;
  assign bus.mem_addr = bus.mem_req ? req_addr : '0;
  assign bus.fq_count = count;
  fetch_fifo u_fifo (
    .clock(clock),
    .reset_n(reset_n),
    .push(push),
    .pop(pop),
    .flush(bus.redirect),
    .din('{pc: req_addr, instr: bus.mem_rdata}),
    .count(count),
    .head(head)
  );
  // next fetch state: an ack always ends the outstanding request, a redirect without ack poisons it
  always_comb begin
    state_n = state == IDLE ? (issue ? WAIT : IDLE)
            : bus.mem_ack ? IDLE
            : bus.redirect ? DROP : state;
  end
  // state, PC and latched request address; redirect wins over a completing fetch
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      req_addr <= '0;
    end else begin
      state <= state_n;
      if (bus.redirect) pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      else if (push) pc <= pc + XLEN'(4);
      if (issue) req_addr <= pc;
    end
  end
  // issue register: popped head appears one cycle later with a single-cycle strobe
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.decode_pulse <= 1'b0;
      bus.instr <= '0;
      bus.instr_pc <= '0;
    end else begin
      bus.decode_pulse <= pop;
      if (pop) begin
        bus.instr <= head.instr;
        bus.instr_pc <= head.pc;
      end
    end
  end
endmodule
